// File: rtl/pi_cmd_queue_pkg.sv
// rtl/pi_cmd_queue_pkg.sv - shared encodings and command record for the Pi command queue
//
// Register-select encodings, STATUS bit positions, ADDR_HI field positions
// and the packed command record carried through the FIFO.
package pi_cmd_queue_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // STATUS word layout: {count[3:0], 8'd0, overflow, rd_valid, full, busy}
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_RD_VALID  = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 12;

    // ADDR_HI write fields; bits [7:0] carry address bits [23:16]
    localparam int RW_BIT   = 9;
    localparam int SIZE_BIT = 8;

    // Address width held in a queued command (ADDR_HI[7:0] ++ ADDR_LO)
    localparam int CMD_AW = 24;

    typedef struct packed {
        logic              rw;
        logic              uds_n;
        logic              lds_n;
        logic [CMD_AW-1:0] addr;
        logic [15:0]       wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/pi_cmd_queue_cmd_fifo.sv
// rtl/pi_cmd_queue_cmd_fifo.sv - synchronous command FIFO with occupancy count
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data enqueue request and payload (ignored when full)
//   pop             dequeue request (ignored when empty)
//   head_data       payload at the head, valid whenever !empty
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
module pi_cmd_queue_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic [3:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pi_cmd_queue.sv
// rtl/pi_cmd_queue.sv - Pi register-port decoder and command queue for the 68K bus sequencer
//
// Ports:
//   PI_CLK, PI_RST          sole clock, synchronous active-high reset
//   pi_wr_stb, pi_rd_stb    one-cycle register write / read pulses
//   pi_a                    register select (DATA, ADDR_LO, ADDR_HI, STATUS)
//   pi_d_in, pi_d_out       Pi write data / registered read data
//   txn_in_progress         queue non-empty or command in flight (registered)
//   ctrl_out                last value written to STATUS
//   op_valid, op_ready      command handshake to the sequencer
//   op_rw, op_addr, op_uds_n, op_lds_n, op_wdata   command fields from FIFO head
//   op_done, op_rdata       completion pulse and read data from the sequencer
module pi_cmd_queue
    import pi_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic          PI_CLK,
    input  logic          PI_RST,
    input  logic          pi_wr_stb,
    input  logic          pi_rd_stb,
    input  logic [1:0]    pi_a,
    input  logic [15:0]   pi_d_in,
    output logic [15:0]   pi_d_out,
    output logic          txn_in_progress,
    output logic [15:0]   ctrl_out,
    output logic          op_valid,
    input  logic          op_ready,
    output logic          op_rw,
    output logic [AW-1:0] op_addr,
    output logic          op_uds_n,
    output logic          op_lds_n,
    output logic [15:0]   op_wdata,
    input  logic          op_done,
    input  logic [15:0]   op_rdata
);

    logic [15:0]      wdata_hold;
    logic [15:0]      addr_lo_hold;
    cmd_t             new_cmd;
    cmd_t             head_cmd;
    logic [CMD_W-1:0] head_bits;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             in_flight;
    logic             in_flight_rw;
    logic             done_ok;
    logic             rd_valid;
    logic [15:0]      rd_data;
    logic             overflow;
    logic             size_byte;
    logic             a0;
    logic [15:0]      status_word;

    assign size_byte = pi_d_in[SIZE_BIT];
    assign a0        = addr_lo_hold[0];

    // A byte access strobes only the lane selected by A0: even address on
    // the upper lane (UDS), odd address on the lower lane (LDS).
    always_comb begin
        new_cmd       = '0;
        new_cmd.rw    = pi_d_in[RW_BIT];
        new_cmd.addr  = {pi_d_in[7:0], addr_lo_hold};
        new_cmd.uds_n = size_byte ? a0 : 1'b0;
        new_cmd.lds_n = size_byte ? !a0 : 1'b0;
        new_cmd.wdata = wdata_hold;
    end

    assign push     = pi_wr_stb && (pi_a == REG_ADDR_HI);
    assign op_valid = !empty && !in_flight;
    assign pop      = op_valid && op_ready;
    // A completion with nothing outstanding is stray and has no effect.
    assign done_ok  = op_done && in_flight;

    pi_cmd_queue_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .clk       (PI_CLK),
        .rst       (PI_RST),
        .push      (push),
        .push_data (new_cmd),
        .pop       (pop),
        .head_data (head_bits),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_cmd = cmd_t'(head_bits);
    assign op_rw    = head_cmd.rw;
    assign op_addr  = AW'(head_cmd.addr);
    assign op_uds_n = head_cmd.uds_n;
    assign op_lds_n = head_cmd.lds_n;
    assign op_wdata = head_cmd.wdata;

    always_comb begin
        status_word                                = '0;
        status_word[ST_COUNT_LSB +: 4]             = count;
        status_word[ST_OVERFLOW]                   = overflow;
        status_word[ST_RD_VALID]                   = rd_valid;
        status_word[ST_FULL]                       = full;
        status_word[ST_BUSY]                       = txn_in_progress;
    end

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            wdata_hold      <= 16'd0;
            addr_lo_hold    <= 16'd0;
            ctrl_out        <= 16'd0;
            overflow        <= 1'b0;
            in_flight       <= 1'b0;
            in_flight_rw    <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= 16'd0;
            pi_d_out        <= 16'd0;
            txn_in_progress <= 1'b0;
        end else begin
            if (pi_wr_stb) begin
                case (pi_a)
                    REG_DATA:    wdata_hold   <= pi_d_in;
                    REG_ADDR_LO: addr_lo_hold <= pi_d_in;
                    REG_STATUS:  ctrl_out     <= pi_d_in;
                    default:     ;
                endcase
            end

            if (pi_rd_stb) begin
                case (pi_a)
                    REG_DATA:   pi_d_out <= rd_data;
                    REG_STATUS: pi_d_out <= status_word;
                    default:    pi_d_out <= 16'd0;
                endcase
            end

            // Clear-on-read first; a same-cycle set takes precedence so no
            // event is lost.
            if (pi_rd_stb && pi_a == REG_STATUS) overflow <= 1'b0;
            if (push && full)                    overflow <= 1'b1;

            if (pi_rd_stb && pi_a == REG_DATA) rd_valid <= 1'b0;
            if (done_ok && in_flight_rw) begin
                rd_data  <= op_rdata;
                rd_valid <= 1'b1;
            end

            // pop requires !in_flight and done_ok requires in_flight, so
            // they never coincide.
            if (pop) begin
                in_flight    <= 1'b1;
                in_flight_rw <= head_cmd.rw;
            end else if (done_ok) begin
                in_flight <= 1'b0;
            end

            txn_in_progress <= !empty || in_flight;
        end
    end

endmodule

// File: tb/tb_pi_cmd_queue.sv
// tb/tb_pi_cmd_queue.sv - randomized self-checking bench for pi_cmd_queue
module tb_pi_cmd_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 24;

    logic          PI_CLK = 1'b0;
    logic          PI_RST = 1'b1;
    logic          pi_wr_stb = 1'b0;
    logic          pi_rd_stb = 1'b0;
    logic [1:0]    pi_a = 2'd0;
    logic [15:0]   pi_d_in = 16'd0;
    logic [15:0]   pi_d_out;
    logic          txn_in_progress;
    logic [15:0]   ctrl_out;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic          op_rw;
    logic [AW-1:0] op_addr;
    logic          op_uds_n;
    logic          op_lds_n;
    logic [15:0]   op_wdata;
    logic          op_done = 1'b0;
    logic [15:0]   op_rdata = 16'd0;

    pi_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PI_CLK          (PI_CLK),
        .PI_RST          (PI_RST),
        .pi_wr_stb       (pi_wr_stb),
        .pi_rd_stb       (pi_rd_stb),
        .pi_a            (pi_a),
        .pi_d_in         (pi_d_in),
        .pi_d_out        (pi_d_out),
        .txn_in_progress (txn_in_progress),
        .ctrl_out        (ctrl_out),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_rw           (op_rw),
        .op_addr         (op_addr),
        .op_uds_n        (op_uds_n),
        .op_lds_n        (op_lds_n),
        .op_wdata        (op_wdata),
        .op_done         (op_done),
        .op_rdata        (op_rdata)
    );

    always #5 PI_CLK = ~PI_CLK;

    typedef struct {
        bit        rw;
        bit [23:0] addr;
        bit        uds_n;
        bit        lds_n;
        bit [15:0] wdata;
    } ent_t;

    // Reference model: a plain queue of pending commands plus scalar flags.
    ent_t      m_q[$];
    bit        m_inflight;
    bit        m_if_rw;
    bit [15:0] m_rd_data;
    bit        m_rd_valid;
    bit        m_ovf;
    bit [15:0] m_ctrl;
    bit [15:0] m_hold;
    bit [15:0] m_lo;
    bit        m_busy;
    bit [15:0] m_dout;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0; m_if_rw = 0; m_rd_data = 0; m_rd_valid = 0;
        m_ovf = 0; m_ctrl = 0; m_hold = 0; m_lo = 0; m_busy = 0; m_dout = 0;
    endtask

    // One clock: drive inputs, advance the model, then check all outputs.
    task automatic cyc(input bit rst, input bit wr, input bit rd, input bit [1:0] a,
                       input bit [15:0] d, input bit rdy, input bit done, input bit [15:0] rdata);
        int  sz;
        bit  pre_full, pre_valid, nb;
        ent_t e;
        PI_RST = rst; pi_wr_stb = wr; pi_rd_stb = rd; pi_a = a; pi_d_in = d;
        op_ready = rdy; op_done = done; op_rdata = rdata;
        if (op_valid && op_ready) hs_cnt++;
        if (rst) begin
            model_reset();
        end else begin
            sz        = m_q.size();
            pre_full  = (sz == DEPTH);
            pre_valid = (sz != 0) && !m_inflight;
            nb        = (sz != 0) || m_inflight;
            if (rd) begin
                if (a == 2'd0) begin
                    m_dout = m_rd_data; m_rd_valid = 0;
                end else if (a == 2'd3) begin
                    m_dout = {4'(sz), 8'd0, m_ovf, m_rd_valid, pre_full, m_busy};
                    m_ovf = 0;
                end else begin
                    m_dout = 16'd0;
                end
            end
            if (wr) begin
                case (a)
                    2'd0: m_hold = d;
                    2'd1: m_lo = d;
                    2'd2: begin
                        if (pre_full) m_ovf = 1;
                        else begin
                            e.rw = d[9];
                            e.addr = {d[7:0], m_lo};
                            e.uds_n = d[8] ? m_lo[0] : 1'b0;
                            e.lds_n = d[8] ? ~m_lo[0] : 1'b0;
                            e.wdata = m_hold;
                            m_q.push_back(e);
                        end
                    end
                    default: m_ctrl = d;
                endcase
            end
            if (m_inflight && done) begin
                m_inflight = 0;
                if (m_if_rw) begin m_rd_data = rdata; m_rd_valid = 1; end
            end else if (pre_valid && rdy) begin
                m_if_rw = m_q[0].rw;
                void'(m_q.pop_front());
                m_inflight = 1;
            end
            m_busy = nb;
        end
        @(posedge PI_CLK);
        @(negedge PI_CLK);
        chk("op_valid", op_valid, (m_q.size() != 0) && !m_inflight);
        if (m_q.size() != 0 && !m_inflight) begin
            chk("op_rw", op_rw, m_q[0].rw);
            chk("op_addr", op_addr, m_q[0].addr);
            chk("op_uds_n", op_uds_n, m_q[0].uds_n);
            chk("op_lds_n", op_lds_n, m_q[0].lds_n);
            chk("op_wdata", op_wdata, m_q[0].wdata);
        end
        chk("pi_d_out", pi_d_out, m_dout);
        chk("txn_in_progress", txn_in_progress, m_busy);
        chk("ctrl_out", ctrl_out, m_ctrl);
    endtask

    task automatic wr_reg(input bit [1:0] a, input bit [15:0] d);
        cyc(0, 1, 0, a, d, 0, 0, 16'd0);
    endtask

    task automatic rd_reg(input bit [1:0] a);
        cyc(0, 0, 1, a, 16'd0, 0, 0, 16'd0);
    endtask

    task automatic idle(input bit rdy, input bit done, input bit [15:0] rdata);
        cyc(0, 0, 0, 2'd0, 16'd0, rdy, done, rdata);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() != 0 || m_inflight) && n < 50) begin
            idle(1, m_inflight, 16'h5A5A);
            n++;
        end
        chk("drain_done", (m_q.size() == 0 && !m_inflight), 1);
    endtask

    initial begin
        model_reset();
        @(negedge PI_CLK);
        cyc(1, 0, 0, 2'd0, 16'd0, 0, 0, 16'd0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_txn", txn_in_progress, 0);
        chk("rst_dout", pi_d_out, 16'h0000);

        // word write
        wr_reg(2'd0, 16'hBEEF);
        wr_reg(2'd1, 16'h1234);
        wr_reg(2'd2, 16'h0000);
        chk("word_valid", op_valid, 1);
        chk("word_addr", op_addr, 24'h001234);
        chk("word_wdata", op_wdata, 16'hBEEF);
        chk("word_strobes", {op_uds_n, op_lds_n}, 2'b00);
        idle(1, 0, 16'd0);
        idle(0, 1, 16'd0);

        // byte read at odd address
        wr_reg(2'd1, 16'h0001);
        wr_reg(2'd2, 16'h0312);
        chk("byte_rw", op_rw, 1);
        chk("byte_addr", op_addr, 24'h120001);
        chk("byte_strobes", {op_uds_n, op_lds_n}, 2'b10);
        idle(1, 0, 16'd0);
        idle(0, 1, 16'h00A5);
        rd_reg(2'd3);
        chk("rdv_set", pi_d_out[2], 1);
        rd_reg(2'd0);
        chk("rd_data", pi_d_out, 16'h00A5);
        rd_reg(2'd3);
        chk("rdv_clr", pi_d_out[2], 0);

        // overflow with DEPTH entries held
        for (int i = 0; i < 5; i++) wr_reg(2'd2, 16'h0000);
        rd_reg(2'd3);
        chk("ovf_status", pi_d_out, 16'h400B);
        rd_reg(2'd3);
        chk("ovf_cleared", pi_d_out, 16'h4003);
        drain();

        // in-flight gating
        wr_reg(2'd2, 16'h0001);
        wr_reg(2'd2, 16'h0002);
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) idle(1, 0, 16'd0);
        chk("one_handshake", hs_cnt, 1);
        idle(0, 1, 16'd0);
        chk("next_valid", op_valid, 1);
        drain();
        idle(0, 1, 16'h7777);
        rd_reg(2'd3);
        chk("stray_done_status", pi_d_out, 16'h0000);

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            wr_reg(2'd0, 16'h1000 + 16'(i));
            wr_reg(2'd1, 16'h0100 + 16'(i));
            wr_reg(2'd2, 16'h0020);
            chk("wrap_wdata", op_wdata, 16'h1000 + 16'(i));
            idle(1, 0, 16'd0);
            idle(0, 1, 16'd0);
        end
        rd_reg(2'd3);
        chk("wrap_count", pi_d_out[15:12], 4'd0);

        // reset mid-operation
        wr_reg(2'd3, 16'h00C3);
        wr_reg(2'd2, 16'h0000);
        idle(1, 0, 16'd0);
        for (int i = 0; i < 3; i++) wr_reg(2'd2, 16'h0000);
        cyc(1, 0, 0, 2'd0, 16'd0, 0, 1, 16'h1111);
        chk("mid_rst_valid", op_valid, 0);
        chk("mid_rst_txn", txn_in_progress, 0);
        chk("mid_rst_ctrl", ctrl_out, 16'h0000);
        rd_reg(2'd3);
        chk("mid_rst_status", pi_d_out, 16'h0000);

        // randomized traffic
        wr_reg(2'd0, 16'(($urandom)));
        wr_reg(2'd1, 16'(($urandom)));
        for (int i = 0; i < 600; i++) begin
            int  r;
            bit  wr, rd, rdy, done;
            bit [1:0] a;
            bit [15:0] d;
            r = $urandom_range(0, 9);
            d = 16'($urandom);
            wr = 0; rd = 0; a = 2'd0;
            case (r)
                0, 1: begin wr = 1; a = 2'd0; end
                2:    begin wr = 1; a = 2'd1; end
                3, 4: begin wr = 1; a = 2'd2; end
                5:    begin wr = 1; a = 2'd3; end
                6, 7: begin rd = 1; a = 2'($urandom_range(0, 3)); end
                default: ;
            endcase
            rdy  = 1'($urandom_range(0, 1));
            done = !rd && ($urandom_range(0, 3) == 0);
            cyc(0, wr, rd, a, d, rdy, done, 16'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pi_cmd_queue.md
Name: pi_cmd_queue

Overview:
Pi-side command front end that sits directly upstream of the 68K bus sequencer. It decodes Pi register-port strobes into complete bus commands and holds them in a small FIFO. It issues the commands one at a time to the sequencer over a valid/ready handshake, captures returned read data, and exposes a status word back to the Pi. Everything runs in the PI_CLK domain; the strobes arrive already synchronised and edge-detected.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..8.
AW, 24, 68K address width carried per command.

Ports:
PI_CLK  in  1  200 MHz Pi-side clock; sole clock.
PI_RST  in  1  synchronous, active-high reset.
pi_wr_stb  in  1  one-cycle pulse: Pi register write.
pi_rd_stb  in  1  one-cycle pulse: Pi register read.
pi_a  in  2  register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
pi_d_in  in  16  write data from Pi.
pi_d_out  out  16  registered read data to Pi.
txn_in_progress  out  1  FIFO non-empty or a command in flight.
ctrl_out  out  16  last value written to STATUS (reset/control bits for the downstream logic).
op_valid  out  1  command available to sequencer.
op_ready  in  1  sequencer accepts command.
op_rw  out  1  1 = read, 0 = write.
op_addr  out  AW  bus address.
op_uds_n  out  1  upper data strobe enable (active low).
op_lds_n  out  1  lower data strobe enable (active low).
op_wdata  out  16  write data.
op_done  in  1  one-cycle pulse: in-flight command finished.
op_rdata  in  16  read data; valid with op_done.

Behaviour:
- Reset: all FIFO pointers, count, in_flight, rd_valid, overflow, pi_d_out, ctrl_out = 0; op_valid = 0; txn_in_progress = 0. Reset mid-operation discards queued entries and in-flight state. An op_done arriving in the same cycle as reset is ignored.
- DATA write: wdata_hold <= pi_d_in.
- ADDR_LO write: addr_lo_hold <= pi_d_in. a0 = pi_d_in[0].
- ADDR_HI write: enqueue the entry {rw = pi_d_in[9], size_byte = pi_d_in[8], addr = {pi_d_in[7:0], addr_lo_hold}, wdata_hold}.
  - Strobe encoding: byte gives uds_n = a0, lds_n = !a0; word gives both 0.
  - If the FIFO is full, the entry is dropped and overflow is set (sticky). Full blocks the enqueue even if a dequeue happens in the same cycle.
- STATUS write: ctrl_out <= pi_d_in. The FIFO is unaffected.
- Issue:
  - op_valid = !empty && !in_flight. The op_* fields are driven from the FIFO head and stay stable while op_valid is high.
  - On op_valid && op_ready, pop the head and set in_flight.
  - At most one command is outstanding.
- Completion:
  - op_done clears in_flight.
  - If the issued command was a read, rd_data <= op_rdata and rd_valid <= 1.
  - op_done while not in_flight is ignored.
- Latency:
  - An ADDR_HI write in cycle N into an empty, idle queue gives op_valid = 1 in cycle N+1.
  - After op_done in cycle M, the next queued entry gives op_valid in cycle M+1.
- Simultaneous enqueue and pop in the same cycle (not full): count is unchanged; both actions take effect.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count is 4 bits, 0..DEPTH.
- Pi read (pi_rd_stb): pi_d_out is registered and updated one cycle after the strobe. It holds its value otherwise.
  - DATA: pi_d_out <= rd_data; rd_valid cleared.
  - STATUS: pi_d_out <= {count[3:0], 8'd0, overflow, rd_valid, full, txn_in_progress}; overflow cleared. The value returned is the pre-clear value.
  - ADDR_LO, ADDR_HI: pi_d_out <= 0.
- txn_in_progress = !empty || in_flight, registered (one-cycle lag).

Decomposition:
- Shared package holds:
  - REG_DATA/REG_ADDR_LO/REG_ADDR_HI/REG_STATUS encodings.
  - STATUS bit indices.
  - ADDR_HI field indices (RW_BIT = 9, SIZE_BIT = 8).
  - The packed command struct {rw, uds_n, lds_n, addr, wdata}.
- One sub-module, cmd_fifo: a synchronous FIFO (push/pop/full/empty/count, DEPTH parameter). The top contains the decode, in-flight tracking and status logic.

Test Plan:
- Word write: DATA = 0xBEEF, ADDR_LO = 0x1234, ADDR_HI = 0x0000 (rw = 0, word) -> next cycle op_valid = 1, op_addr = 0x001234, op_wdata = 0xBEEF, op_uds_n = op_lds_n = 0.
- Byte read at odd address: ADDR_LO = 0x0001, ADDR_HI = 0x0312 -> op_rw = 1, op_addr = 0x120001, op_uds_n = 1, op_lds_n = 0. Then accept, and pulse op_done with op_rdata = 0x00A5 -> STATUS read returns bit2 = 1; DATA read returns 0x00A5; a second STATUS read returns bit2 = 0.
- Hold op_ready = 0 and issue 5 commands with DEPTH = 4 -> STATUS = 0x400B (count 4, overflow, full, busy); a following STATUS read shows overflow = 0.
- In-flight gating: two queued commands, op_ready = 1, no op_done -> exactly one handshake. op_done -> second op_valid one cycle later. op_done with nothing in flight -> no state change.
- Pointer wrap: 10 push/pop cycles with DEPTH = 4 -> issue order and data are preserved, and count returns to 0.
- Assert PI_RST with 3 entries queued and one in flight -> next cycle op_valid = 0, txn_in_progress falls, STATUS reads 0x0000, ctrl_out = 0.
